dso_peak_stats: RTL and testbench
=================================

// Module: dso_peak_stats
// PURPOSE
//  Per-period peak statistics for the DSO front end, next generation of the single-period peak-to-peak meter.
//  Measures max/min/peak-to-peak of ad_data between consecutive rising edges of ad_pulse.
//  Adds: parametrised width, boxcar average of vpp over 2^AVG_LOG2 periods, sample-valid qualifier,
//  and a timeout that free-runs fixed windows when no trigger edge arrives (DC / flat input).
//  Sits between the ADC capture and the measurement readout; ad_pulse comes from the trigger comparator.
// PARAMETERS
//  DATA_W       8        sample width (unsigned)
//  AVG_LOG2     2        log2 of periods averaged for ad_vpp_avg (0 = no averaging)
//  TIMEOUT_CYC  1000000  ad_clk cycles without an edge before a forced window close (>=2)
//  SYNC_STAGES  2        flops synchronising ad_pulse into ad_clk (>=2)
// PORTS
//  ad_clk      in   1        sole clock
//  rst         in   1        reset, synchronous, active-high
//  ad_data     in   DATA_W   ADC sample, unsigned
//  ad_valid    in   1        ad_data qualifier; samples ignored when low
//  ad_pulse    in   1        period marker, asynchronous to ad_clk
//  meas_valid  out  1        one-cycle strobe: ad_max/ad_min/ad_vpp updated
//  ad_max      out  DATA_W   max of last closed window
//  ad_min      out  DATA_W   min of last closed window
//  ad_vpp      out  DATA_W   ad_max - ad_min of last closed window
//  avg_valid   out  1        one-cycle strobe: ad_vpp_avg updated
//  ad_vpp_avg  out  DATA_W   floor(sum of last 2^AVG_LOG2 vpp values / 2^AVG_LOG2)
//  timeout     out  1        high while free-running windows (no edge seen for TIMEOUT_CYC)
// BEHAVIOUR
//  Reset (one cycle of rst high, any time incl. mid-window): all outputs 0, sync chain 0, state IDLE,
//   running max=0 / min=all-ones, sample flag 0, timeout counter 0, avg accumulator and period count 0.
//  Edge: E = first cycle where synced pulse is 1 and its previous value was 0; edge latency SYNC_STAGES+1.
//  FSM: IDLE -> ACQ on first edge E (no publish). In ACQ, window close on edge E or timeout counter = TIMEOUT_CYC-1.
//  Window close at cycle C: if >=1 valid sample in window: cycle C+1 ad_max/ad_min/ad_vpp <= running values,
//   meas_valid=1 for exactly that cycle; else outputs hold, no strobe, window not counted for average.
//  Sample at cycle C (if ad_valid) belongs to the NEW window; running max/min restart from it (or empty).
//  Compare rule: max updates on ad_data > max, min on ad_data < min; vpp = max-min, never negative, DATA_W wide.
//  Timeout counter: counts ad_clk in IDLE and ACQ, cleared on edge and on forced close.
//   In IDLE timeout reaching TIMEOUT_CYC-1 enters ACQ (first forced window starts), no publish.
//   timeout output set at the forced close, cleared on the next edge E (same cycle meas_valid for that window).
//  Averaging: accumulator DATA_W+AVG_LOG2 bits; each published vpp added at C+1; on the 2^AVG_LOG2-th,
//   ad_vpp_avg <= sum>>AVG_LOG2 and avg_valid=1 at C+2, accumulator and count clear. Forced windows count.
//  AVG_LOG2=0: avg_valid/ad_vpp_avg follow every meas_valid one cycle later.
//  Back-to-back closes (edges 1 cycle apart after sync) each publish independently; no close is dropped.
//  ad_pulse glitch shorter than one ad_clk may be missed; no other filtering.
// TESTING
//  T1 DATA_W=8: samples 10,200,50,3,90 between edges -> meas_valid once, ad_max=200 ad_min=3 ad_vpp=197.
//  T2 AVG_LOG2=2: four periods vpp 100,101,102,104 -> avg_valid once, ad_vpp_avg=101 (407>>2), two cycles after 4th close.
//  T3 ad_valid low on the 255 sample, high elsewhere (max 40) -> ad_max=40; window all-invalid -> no meas_valid.
//  T4 TIMEOUT_CYC=16, no edges, constant 77 -> timeout=1, meas_valid every 16 cycles, vpp=0; edge -> timeout=0.
//  T5 rst asserted mid-window -> next cycle all outputs 0; first edge after reset publishes nothing.
//  T6 two edges 1 synced cycle apart -> two meas_valid strobes; second window holds the single edge-cycle sample.

Source files
------------

// File: rtl/dso_peak_stats.sv
// Per-period max/min/peak-to-peak of ad_data between rising edges of ad_pulse,
// with a boxcar average of vpp and a timeout that free-runs windows when no edge arrives.
module dso_peak_stats #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              ad_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              ad_valid,
    input  logic              ad_pulse,
    output logic              meas_valid,
    output logic [DATA_W-1:0] ad_max,
    output logic [DATA_W-1:0] ad_min,
    output logic [DATA_W-1:0] ad_vpp,
    output logic              avg_valid,
    output logic [DATA_W-1:0] ad_vpp_avg,
    output logic              timeout
);

    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC);
    localparam int unsigned ACNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned SUM_W  = DATA_W + AVG_LOG2;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [0:0] {StIdle, StAcq} state_e;

    state_e                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     pulse_prev_q;
    logic [TCNT_W-1:0]        tcnt_q, tcnt_d;
    logic [DATA_W-1:0]        run_max_q, run_max_d;
    logic [DATA_W-1:0]        run_min_q, run_min_d;
    logic                     seen_q, seen_d;
    logic                     timeout_q, timeout_d;
    logic                     meas_valid_q, meas_valid_d;
    logic [DATA_W-1:0]        max_q, max_d;
    logic [DATA_W-1:0]        min_q, min_d;
    logic [DATA_W-1:0]        vpp_q, vpp_d;
    logic [SUM_W-1:0]         acc_q, acc_d;
    logic [ACNT_W-1:0]        acnt_q, acnt_d;
    logic                     avg_valid_q, avg_valid_d;
    logic [DATA_W-1:0]        avg_q, avg_d;

    logic                     edge_det;
    logic                     tc_hit;
    logic                     restart;
    logic [SUM_W-1:0]         sum_next;

    assign edge_det = sync_q[SYNC_STAGES-1] & ~pulse_prev_q;
    assign tc_hit   = (tcnt_q == TCNT_LAST);
    assign sum_next = acc_q + SUM_W'(vpp_q);

    always_comb begin
        state_d      = state_q;
        tcnt_d       = tcnt_q + TCNT_W'(1);
        run_max_d    = run_max_q;
        run_min_d    = run_min_q;
        seen_d       = seen_q;
        timeout_d    = timeout_q;
        meas_valid_d = 1'b0;
        max_d        = max_q;
        min_d        = min_q;
        vpp_d        = vpp_q;
        restart      = 1'b0;

        case (state_q)
            StIdle: begin
                if (edge_det || tc_hit) begin
                    state_d   = StAcq;
                    restart   = 1'b1;
                    timeout_d = ~edge_det;
                end
            end
            StAcq: begin
                if (edge_det || tc_hit) begin
                    restart   = 1'b1;
                    timeout_d = ~edge_det;
                    if (seen_q) begin
                        meas_valid_d = 1'b1;
                        max_d        = run_max_q;
                        min_d        = run_min_q;
                        vpp_d        = run_max_q - run_min_q;
                    end
                end else if (ad_valid) begin
                    seen_d = 1'b1;
                    if (ad_data > run_max_q) run_max_d = ad_data;
                    if (ad_data < run_min_q) run_min_d = ad_data;
                end
            end
            default: state_d = StIdle;
        endcase

        // The sample on the closing cycle opens the next window.
        if (restart) begin
            tcnt_d    = '0;
            seen_d    = ad_valid;
            run_max_d = ad_valid ? ad_data : '0;
            run_min_d = ad_valid ? ad_data : '1;
        end
    end

    always_comb begin
        acc_d       = acc_q;
        acnt_d      = acnt_q;
        avg_valid_d = 1'b0;
        avg_d       = avg_q;
        if (meas_valid_q) begin
            if (acnt_q == ACNT_LAST) begin
                avg_d       = sum_next[AVG_LOG2 +: DATA_W];
                avg_valid_d = 1'b1;
                acc_d       = '0;
                acnt_d      = '0;
            end else begin
                acc_d  = sum_next;
                acnt_d = acnt_q + ACNT_W'(1);
            end
        end
    end

    always_ff @(posedge ad_clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sync_q       <= '0;
            pulse_prev_q <= 1'b0;
            tcnt_q       <= '0;
            run_max_q    <= '0;
            run_min_q    <= '1;
            seen_q       <= 1'b0;
            timeout_q    <= 1'b0;
            meas_valid_q <= 1'b0;
            max_q        <= '0;
            min_q        <= '0;
            vpp_q        <= '0;
            acc_q        <= '0;
            acnt_q       <= '0;
            avg_valid_q  <= 1'b0;
            avg_q        <= '0;
        end else begin
            state_q      <= state_d;
            sync_q       <= {sync_q[SYNC_STAGES-2:0], ad_pulse};
            pulse_prev_q <= sync_q[SYNC_STAGES-1];
            tcnt_q       <= tcnt_d;
            run_max_q    <= run_max_d;
            run_min_q    <= run_min_d;
            seen_q       <= seen_d;
            timeout_q    <= timeout_d;
            meas_valid_q <= meas_valid_d;
            max_q        <= max_d;
            min_q        <= min_d;
            vpp_q        <= vpp_d;
            acc_q        <= acc_d;
            acnt_q       <= acnt_d;
            avg_valid_q  <= avg_valid_d;
            avg_q        <= avg_d;
        end
    end

    assign meas_valid = meas_valid_q;
    assign ad_max     = max_q;
    assign ad_min     = min_q;
    assign ad_vpp     = vpp_q;
    assign avg_valid  = avg_valid_q;
    assign ad_vpp_avg = avg_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_dso_peak_stats.sv
// Directed bench for dso_peak_stats: a main instance for windows/averaging/reset and a
// short-timeout instance for free-running windows.
module tb_dso_peak_stats;

    logic       ad_clk = 1'b0;
    logic       rst;
    logic [7:0] ad_data;
    logic       ad_valid;
    logic       ad_pulse;
    logic       meas_valid;
    logic [7:0] ad_max;
    logic [7:0] ad_min;
    logic [7:0] ad_vpp;
    logic       avg_valid;
    logic [7:0] ad_vpp_avg;
    logic       timeout;

    logic       to_rst;
    logic [7:0] to_data;
    logic       to_valid;
    logic       to_pulse;
    logic       to_meas_valid;
    logic [7:0] to_max;
    logic [7:0] to_min;
    logic [7:0] to_vpp;
    logic       to_avg_valid;
    logic [7:0] to_vpp_avg;
    logic       to_timeout;

    int errors = 0;
    int checks = 0;

    always #5 ad_clk = ~ad_clk;

    dso_peak_stats #(
        .DATA_W      (8),
        .AVG_LOG2    (2),
        .TIMEOUT_CYC (64),
        .SYNC_STAGES (2)
    ) dut (
        .ad_clk     (ad_clk),
        .rst        (rst),
        .ad_data    (ad_data),
        .ad_valid   (ad_valid),
        .ad_pulse   (ad_pulse),
        .meas_valid (meas_valid),
        .ad_max     (ad_max),
        .ad_min     (ad_min),
        .ad_vpp     (ad_vpp),
        .avg_valid  (avg_valid),
        .ad_vpp_avg (ad_vpp_avg),
        .timeout    (timeout)
    );

    dso_peak_stats #(
        .DATA_W      (8),
        .AVG_LOG2    (0),
        .TIMEOUT_CYC (16),
        .SYNC_STAGES (2)
    ) dut_to (
        .ad_clk     (ad_clk),
        .rst        (to_rst),
        .ad_data    (to_data),
        .ad_valid   (to_valid),
        .ad_pulse   (to_pulse),
        .meas_valid (to_meas_valid),
        .ad_max     (to_max),
        .ad_min     (to_min),
        .ad_vpp     (to_vpp),
        .avg_valid  (to_avg_valid),
        .ad_vpp_avg (to_vpp_avg),
        .timeout    (to_timeout)
    );

    task automatic tick();
        @(posedge ad_clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] d, input logic v, input logic p);
        ad_data  = d;
        ad_valid = v;
        ad_pulse = p;
        tick();
    endtask

    // Pulse high for two cycles; the third call carries the sample of the closing cycle.
    task automatic fire_edge(input logic [7:0] d, input logic v);
        feed(8'd0, 1'b0, 1'b1);
        feed(8'd0, 1'b0, 1'b1);
        feed(d, v, 1'b0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        ad_data  = 8'd0;
        ad_valid = 1'b0;
        ad_pulse = 1'b0;
        to_rst   = 1'b1;
        to_data  = 8'd77;
        to_valid = 1'b1;
        to_pulse = 1'b0;
        tick();
        tick();
        chk("rst_meas_valid", 32'(meas_valid), 0);
        chk("rst_max", 32'(ad_max), 0);
        chk("rst_min", 32'(ad_min), 0);
        chk("rst_vpp", 32'(ad_vpp), 0);
        chk("rst_avg_valid", 32'(avg_valid), 0);
        chk("rst_avg", 32'(ad_vpp_avg), 0);
        chk("rst_timeout", 32'(timeout), 0);
        rst = 1'b0;

        // T1: first edge arms, second edge publishes 10,200,50,3,90
        fire_edge(8'd0, 1'b0);
        chk("t1_first_edge_no_pub", 32'(meas_valid), 0);
        feed(8'd10, 1'b1, 1'b0);
        feed(8'd200, 1'b1, 1'b0);
        feed(8'd50, 1'b1, 1'b0);
        feed(8'd3, 1'b1, 1'b0);
        feed(8'd90, 1'b1, 1'b0);
        fire_edge(8'd0, 1'b0);
        chk("t1_meas_valid", 32'(meas_valid), 1);
        chk("t1_max", 32'(ad_max), 200);
        chk("t1_min", 32'(ad_min), 3);
        chk("t1_vpp", 32'(ad_vpp), 197);
        feed(8'd0, 1'b0, 1'b0);
        chk("t1_strobe_one_cycle", 32'(meas_valid), 0);

        // T3: invalid 255 ignored; then an all-invalid window publishes nothing
        feed(8'd255, 1'b0, 1'b0);
        feed(8'd40, 1'b1, 1'b0);
        feed(8'd12, 1'b1, 1'b0);
        feed(8'd7, 1'b0, 1'b0);
        feed(8'd30, 1'b1, 1'b0);
        fire_edge(8'd0, 1'b0);
        chk("t3_meas_valid", 32'(meas_valid), 1);
        chk("t3_max", 32'(ad_max), 40);
        chk("t3_min", 32'(ad_min), 12);
        chk("t3_vpp", 32'(ad_vpp), 28);
        feed(8'd9, 1'b0, 1'b0);
        feed(8'd250, 1'b0, 1'b0);
        fire_edge(8'd0, 1'b0);
        chk("t3_empty_no_strobe", 32'(meas_valid), 0);
        chk("t3_empty_hold_max", 32'(ad_max), 40);
        chk("t3_no_timeout", 32'(timeout), 0);

        // T5: reset mid-window
        feed(8'd99, 1'b1, 1'b0);
        feed(8'd150, 1'b1, 1'b0);
        rst = 1'b1;
        feed(8'd5, 1'b1, 1'b0);
        rst = 1'b0;
        chk("t5_meas_valid", 32'(meas_valid), 0);
        chk("t5_max", 32'(ad_max), 0);
        chk("t5_min", 32'(ad_min), 0);
        chk("t5_vpp", 32'(ad_vpp), 0);
        chk("t5_avg", 32'(ad_vpp_avg), 0);
        fire_edge(8'd0, 1'b0);
        chk("t5_first_edge_no_pub", 32'(meas_valid), 0);
        chk("t5_first_edge_max", 32'(ad_max), 0);

        // T2: vpp 100,101,102,104 -> average 101 two cycles after the fourth close
        feed(8'd10, 1'b1, 1'b0);
        feed(8'd110, 1'b1, 1'b0);
        fire_edge(8'd0, 1'b0);
        chk("t2_p1_vpp", 32'(ad_vpp), 100);
        chk("t2_p1_no_avg", 32'(avg_valid), 0);
        feed(8'd0, 1'b1, 1'b0);
        feed(8'd101, 1'b1, 1'b0);
        fire_edge(8'd0, 1'b0);
        chk("t2_p2_vpp", 32'(ad_vpp), 101);
        feed(8'd152, 1'b1, 1'b0);
        feed(8'd50, 1'b1, 1'b0);
        fire_edge(8'd0, 1'b0);
        chk("t2_p3_vpp", 32'(ad_vpp), 102);
        feed(8'd105, 1'b1, 1'b0);
        feed(8'd1, 1'b1, 1'b0);
        fire_edge(8'd0, 1'b0);
        chk("t2_p4_meas_valid", 32'(meas_valid), 1);
        chk("t2_p4_vpp", 32'(ad_vpp), 104);
        chk("t2_avg_not_yet", 32'(avg_valid), 0);
        feed(8'd0, 1'b0, 1'b0);
        chk("t2_avg_valid", 32'(avg_valid), 1);
        chk("t2_avg", 32'(ad_vpp_avg), 101);
        feed(8'd0, 1'b0, 1'b0);
        chk("t2_avg_strobe_one_cycle", 32'(avg_valid), 0);
        chk("t2_avg_hold", 32'(ad_vpp_avg), 101);

        // T6: two edges with one low synced cycle between
        feed(8'd60, 1'b1, 1'b0);
        feed(8'd20, 1'b1, 1'b0);
        feed(8'd0, 1'b0, 1'b1);
        feed(8'd0, 1'b0, 1'b0);
        feed(8'd123, 1'b1, 1'b1);
        chk("t6_first_strobe", 32'(meas_valid), 1);
        chk("t6_first_vpp", 32'(ad_vpp), 40);
        feed(8'd0, 1'b0, 1'b0);
        chk("t6_gap", 32'(meas_valid), 0);
        feed(8'd0, 1'b0, 1'b0);
        chk("t6_second_strobe", 32'(meas_valid), 1);
        chk("t6_second_max", 32'(ad_max), 123);
        chk("t6_second_min", 32'(ad_min), 123);
        chk("t6_second_vpp", 32'(ad_vpp), 0);

        // T4: constant 77, no edges, TIMEOUT_CYC=16
        to_rst = 1'b1;
        tick();
        to_rst = 1'b0;
        for (int k = 1; k <= 31; k++) tick();
        chk("t4_no_strobe_before_first", 32'(to_meas_valid), 0);
        tick();
        chk("t4_first_forced_strobe", 32'(to_meas_valid), 1);
        chk("t4_timeout_set", 32'(to_timeout), 1);
        chk("t4_vpp", 32'(to_vpp), 0);
        chk("t4_max", 32'(to_max), 77);
        chk("t4_min", 32'(to_min), 77);
        tick();
        chk("t4_avg_follows", 32'(to_avg_valid), 1);
        chk("t4_strobe_one_cycle", 32'(to_meas_valid), 0);
        for (int k = 34; k <= 47; k++) tick();
        chk("t4_no_early_second", 32'(to_meas_valid), 0);
        tick();
        chk("t4_second_forced_strobe", 32'(to_meas_valid), 1);
        chk("t4_timeout_held", 32'(to_timeout), 1);
        to_pulse = 1'b1;
        tick();
        tick();
        to_pulse = 1'b0;
        tick();
        chk("t4_edge_strobe", 32'(to_meas_valid), 1);
        chk("t4_edge_clears_timeout", 32'(to_timeout), 0);
        chk("t4_edge_max", 32'(to_max), 77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
